// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the uart_tx feeder: sequencer states and default sizing.
package uart_tx_feeder_pkg;

    localparam int DEFAULT_DATA_BITS    = 8;
    localparam int DEFAULT_DEPTH_LOG2   = 4;
    localparam int DEFAULT_BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_START      = 2'd1,
        ST_WAIT_BUSY  = 2'd2,
        ST_WAIT_READY = 2'd3
    } seq_state_e;

    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock byte FIFO with registered occupancy flags and a sticky overflow bit.
module sync_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_BITS-1:0]  wr_data,
    input  logic                  rd_en,
    output logic [DATA_BITS-1:0]  rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = fifo_depth(DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  push;
    logic                  pop;

    // full is the registered pre-pop flag, so a push racing a pop on a full FIFO is dropped
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_nxt;
            full     <= (count_nxt == DEPTH_CNT);
            empty    <= (count_nxt == '0);
            overflow <= overflow | (wr_en & full);
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them to uart_tx one at a time, one start pulse per
// observed ready->busy->ready cycle, with a timeout if the transmitter never goes busy.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int DEPTH_LOG2   = DEFAULT_DEPTH_LOG2,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_BITS-1:0]  wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  tx_ready,
    output logic                  tx_start,
    output logic [DATA_BITS-1:0]  tx_data
);

    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    seq_state_e           state;
    seq_state_e           state_nxt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [TMO_W-1:0]     tmo_cnt_nxt;
    logic                 pop;
    logic                 tx_start_nxt;
    logic [DATA_BITS-1:0] head;

    sync_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow)
    );

    always_comb begin
        state_nxt    = state;
        tmo_cnt_nxt  = tmo_cnt;
        pop          = 1'b0;
        tx_start_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && tx_ready) begin
                    pop          = 1'b1;
                    tx_start_nxt = 1'b1;
                    state_nxt    = ST_START;
                end
            end
            ST_START: begin
                tmo_cnt_nxt = '0;
                state_nxt   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A transmitter that never drops ready still releases the byte slot
                if (!tx_ready) begin
                    state_nxt = ST_WAIT_READY;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            ST_WAIT_READY: begin
                if (tx_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tmo_cnt  <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
            tx_start <= tx_start_nxt;
            if (pop) begin
                tx_data <= head;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomised and directed bench for uart_tx_feeder against a cycle-timestamp reference model.
module tb_uart_tx_feeder;

    localparam int DB    = 8;
    localparam int DL    = 4;
    localparam int BT    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [DB-1:0] wr_data = '0;
    logic          tx_ready = 1'b1;
    logic          full, empty, overflow, tx_start;
    logic [DL:0]   count;
    logic [DB-1:0] tx_data;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DATA_BITS   (DB),
        .DEPTH_LOG2  (DL),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow),
        .tx_ready(tx_ready),
        .tx_start(tx_start),
        .tx_data (tx_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready stub: mode 0 = busy for stub_len cycles after each start, 1 = always ready, 2 = never ready
    int stub_mode = 0;
    int stub_len  = 40;
    int busy_left = 0;
    int n_starts  = 0;
    int start_gap = 0;
    int last_start = 0;
    int tcount = 0;

    initial begin
        bit seen;
        forever begin
            @(negedge clk);
            seen = tx_start;
            if (tx_start) begin
                start_gap  = tcount - last_start;
                last_start = tcount;
                n_starts++;
            end
            tcount++;
            @(posedge clk);
            #1;
            if (!rst_n) busy_left = 0;
            else if (seen) busy_left = stub_len;
            else if (busy_left > 0) busy_left--;
            case (stub_mode)
                0:       tx_ready = (busy_left == 0);
                1:       tx_ready = 1'b1;
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Reference model: queue of bytes plus the cycle of the last start pulse
    logic [DB-1:0] mq[$];
    bit            m_free = 1'b1;
    bit            m_low = 1'b0;
    int            m_st_at = 0;
    int            m_t = 0;
    bit            m_ovf = 1'b0;
    bit            m_start = 1'b0;
    logic [DB-1:0] m_txd = '0;

    initial begin
        bit do_pop, can_push;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                m_free = 1'b1; m_low = 1'b0; m_ovf = 1'b0; m_start = 1'b0; m_txd = '0;
            end
            chk("count",    int'(count),    mq.size());
            chk("empty",    int'(empty),    int'(mq.size() == 0));
            chk("full",     int'(full),     int'(mq.size() == DEPTH));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("tx_start", int'(tx_start), int'(m_start));
            chk("tx_data",  int'(tx_data),  int'(m_txd));
            if (rst_n) begin
                do_pop   = m_free && mq.size() != 0 && tx_ready;
                can_push = mq.size() < DEPTH;
                m_start  = do_pop;
                if (do_pop) begin
                    m_txd   = mq.pop_front();
                    m_free  = 1'b0;
                    m_st_at = m_t + 1;
                    m_low   = 1'b0;
                end else if (!m_free && m_t > m_st_at) begin
                    if (m_low) begin
                        if (tx_ready) m_free = 1'b1;
                    end else if (!tx_ready) begin
                        m_low = 1'b1;
                    end else if (m_t - m_st_at >= BT) begin
                        m_free = 1'b1;
                    end
                end
                if (wr_en) begin
                    if (can_push) mq.push_back(wr_data);
                    else m_ovf = 1'b1;
                end
            end
            m_t++;
        end
    end

    task automatic drive(input bit en, input logic [DB-1:0] d);
        @(posedge clk);
        #2;
        wr_en   = en;
        wr_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        wr_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_start", int'(tx_start), 0);
        chk("rst_data", int'(tx_data), 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic wait_starts(input int target, input int budget);
        int k = 0;
        while (n_starts < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("starts_reached", int'(n_starts >= target), 1);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (!(mq.size() == 0 && m_free && tx_ready) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drained", int'(mq.size() == 0 && m_free), 1);
    endtask

    initial begin
        int n0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_empty", int'(empty), 1);
        idle(2);

        // Single byte: start exactly two cycles after the push
        drive(1'b1, 8'h54);
        @(negedge clk); chk("single_s0", int'(tx_start), 0);
        drive(1'b0, '0);
        @(negedge clk); chk("single_s1", int'(tx_start), 0);
        @(negedge clk); chk("single_s2", int'(tx_start), 1);
        chk("single_data", int'(tx_data), 8'h54);
        @(negedge clk); chk("single_s3", int'(tx_start), 0);
        wait_drain(200);

        // Burst behind a uart-like busy period
        n0 = n_starts;
        drive(1'b1, 8'h41); drive(1'b1, 8'h42); drive(1'b1, 8'h43); idle(1);
        wait_starts(n0 + 3, 400);
        wait_drain(200);
        chk("burst_starts", n_starts - n0, 3);

        // Reset in the middle of the second byte
        n0 = n_starts;
        drive(1'b1, 8'h31); drive(1'b1, 8'h32); drive(1'b1, 8'h33); idle(1);
        wait_starts(n0 + 2, 400);
        idle(5);
        pulse_reset();
        idle(60);
        chk("rst_no_start", n_starts - n0, 2);
        chk("rst_count_after", int'(count), 0);

        // Overflow with the transmitter held busy
        stub_mode = 2;
        idle(2);
        for (int i = 0; i < 17; i++) drive(1'b1, 8'(8'h60 + i));
        idle(1);
        @(negedge clk);
        chk("ovf_count", int'(count), 16);
        chk("ovf_full", int'(full), 1);
        chk("ovf_flag", int'(overflow), 1);
        stub_len  = 3;
        stub_mode = 0;
        wait_drain(400);
        @(negedge clk);
        chk("ovf_empty_end", int'(empty), 1);
        chk("ovf_sticky", int'(overflow), 1);

        // Push on a full FIFO in the same cycle the sequencer pops
        pulse_reset();
        stub_mode = 2;
        idle(2);
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h80 + i));
        idle(1);
        stub_mode = 1;
        drive(1'b1, 8'hEE);
        drive(1'b0, '0);
        @(negedge clk);
        chk("pp_count", int'(count), 15);
        chk("pp_ovf", int'(overflow), 1);
        wait_drain(300);

        // Ready never drops: timeout releases each byte
        n0 = n_starts;
        drive(1'b1, 8'hA1); drive(1'b1, 8'hA2); drive(1'b1, 8'hA3); idle(1);
        wait_starts(n0 + 3, 100);
        chk("timeout_gap", start_gap, 6);
        wait_drain(100);

        // Randomised traffic
        pulse_reset();
        for (int seg = 0; seg < 24; seg++) begin
            int sel, dens;
            sel  = $urandom_range(0, 4);
            dens = $urandom_range(0, 4);
            stub_len  = $urandom_range(0, 8);
            stub_mode = (sel <= 2) ? 0 : (sel == 3 ? 1 : 2);
            if (seg == 12) pulse_reset();
            for (int c = 0; c < 80; c++)
                drive(($urandom_range(0, dens) == 0), 8'($urandom));
        end
        drive(1'b0, '0);
        stub_mode = 1;
        wait_drain(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
